// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcodes, control states and result flags.
// Build option ALU_SEQ_DIV_EN enables the iterative divider (opcode DIV).
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    MUL  = 4'd2,
    AND  = 4'd3,
    OR   = 4'd4,
    NAND = 4'd5,
    NOR  = 4'd6,
    XOR  = 4'd7,
    DIV  = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
    logic err;
  } flags_t;

  function automatic flags_t err_only_flags();
    flags_t f;
    f     = '0;
    f.err = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative datapath: unsigned shift-add multiply, plus restoring divide when
// ALU_SEQ_DIV_EN is defined. One step per cycle; 'last' marks the final step.
module alu_seq_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_SEQ_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] addend;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
`ifdef ALU_SEQ_DIV_EN
  logic             div_mode;
  logic [WIDTH:0]   shifted;
`endif

  assign last = busy && (cnt == CNT_W'(1));

  // Next partial product / remainder for the current step
  always_comb begin
    if (lo[0]) begin
      mul_sum = {1'b0, hi} + {1'b0, addend};
    end else begin
      mul_sum = {1'b0, hi};
    end
    mul_hi = mul_sum[WIDTH:1];
    mul_lo = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
    // Remainder lives in hi, quotient bits shift into lo as dividend bits leave
    shifted = {hi, lo[WIDTH-1]};
    if (div_mode) begin
      if (shifted >= {1'b0, addend}) begin
        hi_next = shifted[WIDTH-1:0] - addend;
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = mul_hi;
      lo_next = mul_lo;
    end
`else
    hi_next = mul_hi;
    lo_next = mul_lo;
`endif
  end

  // Operand load on start, then one step per cycle until the counter expires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      addend <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_mode <= 1'b0;
`endif
    end else if (start) begin
      hi   <= '0;
      cnt  <= CNT_W'(WIDTH);
      busy <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
      div_mode <= is_div;
      lo       <= is_div ? a : b;
      addend   <= is_div ? b : a;
`else
      lo     <= b;
      addend <= a;
`endif
    end else if (busy) begin
      hi   <= hi_next;
      lo   <= lo_next;
      cnt  <= cnt - CNT_W'(1);
      busy <= (cnt != CNT_W'(1));
    end else begin
      busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle add/sub/logic, iterative MUL, and
// iterative DIV when ALU_SEQ_DIV_EN is defined (otherwise opcode 8 is illegal).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flagC,
  output logic             flagZ,
  output logic             flagN,
  output logic             flagV,
  output logic             flag_err
);

  state_e           state;
  opcode_e          op;
  flags_t           flags;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_diff;
  logic [WIDTH-1:0] op_res;
  flags_t           op_flags;
  logic             legal;
  logic             is_iter;
  logic             accept;
  logic             iter_last;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;
  flags_t           iter_flags;
`ifdef ALU_SEQ_DIV_EN
  logic             b_zero;
`endif

  assign accept = (state == IDLE) && in_valid && in_ready;

  // Single-cycle result and flags straight from the issuing operands
  always_comb begin
    add_sum  = {1'b0, operand1} + {1'b0, operand2};
    sub_diff = {1'b0, operand1} - {1'b0, operand2};
    op_res   = '0;
    op_flags = '0;
    legal    = 1'b1;
    is_iter  = 1'b0;
    case (opcode)
      ADD: begin
        op_res     = add_sum[WIDTH-1:0];
        op_flags.c = add_sum[WIDTH];
        op_flags.v = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != operand1[WIDTH-1]);
      end
      SUB: begin
        op_res     = sub_diff[WIDTH-1:0];
        op_flags.c = sub_diff[WIDTH];
        op_flags.v = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                     (sub_diff[WIDTH-1] != operand1[WIDTH-1]);
      end
      MUL:  is_iter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
      DIV:  is_iter = 1'b1;
`endif
      AND:  op_res = operand1 & operand2;
      OR:   op_res = operand1 | operand2;
      NAND: op_res = ~(operand1 & operand2);
      NOR:  op_res = ~(operand1 | operand2);
      XOR:  op_res = operand1 ^ operand2;
      default: legal = 1'b0;
    endcase
    if (legal) begin
      op_flags.z = (op_res == '0);
      op_flags.n = op_res[WIDTH-1];
    end else begin
      op_flags = err_only_flags();
    end
  end

  alu_seq_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (accept && is_iter),
`ifdef ALU_SEQ_DIV_EN
    .is_div  (opcode == DIV),
`endif
    .a       (operand1),
    .b       (operand2),
    .last    (iter_last),
    .lo_next (iter_lo),
    .hi_next (iter_hi)
  );

  // Flags for the final iterative step; a zero divisor still runs full length
  always_comb begin
    iter_flags     = '0;
    iter_flags.z   = (iter_lo == '0);
    iter_flags.n   = iter_lo[WIDTH-1];
    iter_flags.c   = (op == MUL) && (iter_hi != '0);
`ifdef ALU_SEQ_DIV_EN
    iter_flags.err = (op == DIV) && b_zero;
`endif
  end

  // Control FSM with registered handshake, result and flag outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op        <= ADD;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
`ifdef ALU_SEQ_DIV_EN
      b_zero    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op       <= opcode_e'(opcode);
            in_ready <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            b_zero   <= (operand2 == '0);
`endif
            if (is_iter) begin
              state <= BUSY;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= op_res;
              result_hi <= '0;
              flags     <= op_flags;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        BUSY: begin
          if (iter_last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= iter_lo;
            result_hi <= iter_hi;
            flags     <= iter_flags;
          end else begin
            out_valid <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign flagC    = flags.c;
  assign flagZ    = flags.z;
  assign flagN    = flags.n;
  assign flagV    = flags.v;
  assign flag_err = flags.err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32): vector table plus backpressure and
// reset-abort sequences. DIV expectations follow the ALU_SEQ_DIV_EN build option.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = 4'd0;
  logic [31:0] operand1 = 32'd0;
  logic [31:0] operand2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [31:0] result_hi;
  logic        flagC, flagZ, flagN, flagV, flag_err;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .flagC(flagC), .flagZ(flagZ), .flagN(flagN), .flagV(flagV), .flag_err(flag_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [31:0] hi;
    logic [4:0]  fl;   // {C,Z,N,V,err}
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op, measure edges from acceptance to out_valid, capture, then retire it
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic [31:0] hi,
                       output logic [4:0] fl, output int lat, output logic ready_seen);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; opcode = op; operand1 = a; operand2 = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    ready_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      ready_seen |= in_ready;
      @(posedge clk); #1;
      lat++;
    end
    ready_seen |= in_ready;
    res = result; hi = result_hi;
    fl  = {flagC, flagZ, flagN, flagV, flag_err};
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] r, h;
    logic [4:0]  f;
    int          lat;
    logic        rdy;
    logic        seen;
    int          guard;

    vecs.push_back('{ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 5'b11000, 1});
    vecs.push_back('{SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 5'b00010, 1});
    vecs.push_back('{SUB,  32'h00000003, 32'h00000005, 32'hFFFFFFFE, 32'h0, 5'b10100, 1});
    vecs.push_back('{ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 5'b00110, 1});
    vecs.push_back('{MUL,  32'h00010000, 32'h00010000, 32'h00000000, 32'h1, 5'b11000, 33});
    vecs.push_back('{MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 5'b10000, 33});
    vecs.push_back('{MUL,  32'h00000006, 32'h00000007, 32'h0000002A, 32'h0, 5'b00000, 33});
    vecs.push_back('{AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 5'b00000, 1});
    vecs.push_back('{OR,   32'h80000000, 32'h00000001, 32'h80000001, 32'h0, 5'b00100, 1});
    vecs.push_back('{NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 5'b01000, 1});
    vecs.push_back('{NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 5'b00100, 1});
    vecs.push_back('{XOR,  32'h12345678, 32'h12345678, 32'h00000000, 32'h0, 5'b01000, 1});
    vecs.push_back('{4'd12, 32'h00000005, 32'h00000003, 32'h00000000, 32'h0, 5'b00001, 1});
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back('{DIV,  32'd100, 32'd7, 32'd14, 32'd2, 5'b00000, 33});
    vecs.push_back('{DIV,  32'd5,   32'd0, 32'hFFFFFFFF, 32'd5, 5'b00101, 33});
`else
    vecs.push_back('{DIV,  32'd100, 32'd7, 32'h0, 32'h0, 5'b00001, 1});
`endif

    // Reset state and in_ready release timing
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 1'b0);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst result", {result_hi, result}, 64'h0);
    chk("rst flags", {flagC, flagZ, flagN, flagV, flag_err}, 5'b00000);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("release in_ready before clk", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("release in_ready after clk", in_ready, 1'b1);

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, h, f, lat, rdy);
      chk($sformatf("vec%0d result", i), r, vecs[i].res);
      chk($sformatf("vec%0d result_hi", i), h, vecs[i].hi);
      chk($sformatf("vec%0d flags", i), f, vecs[i].fl);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d in_ready low", i), rdy, 1'b0);
      chk($sformatf("vec%0d retired", i), out_valid, 1'b0);
    end

    // Backpressure: result held while out_ready is low, new issue ignored
    @(negedge clk);
    in_valid = 1'b1; opcode = XOR; operand1 = 32'hF0F0F0F0; operand2 = 32'hFFFFFFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d out_valid", i), out_valid, 1'b1);
      chk($sformatf("bp%0d result", i), result, 32'h0F0F0F0F);
      chk($sformatf("bp%0d in_ready", i), in_ready, 1'b0);
      @(negedge clk);
      in_valid = 1'b1; opcode = ADD; operand1 = 32'd1; operand2 = 32'd1;
      @(posedge clk); #1;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("bp completes", out_valid, 1'b0);
    seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("bp ignored issue", seen, 1'b0);
    chk("bp back to idle", in_ready, 1'b1);

    // Reset at cycle 10 of a MUL aborts it with no out_valid
    @(negedge clk);
    in_valid = 1'b1; opcode = MUL; operand1 = 32'h00010000; operand2 = 32'h00010000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort in_ready", in_ready, 1'b0);
    chk("abort result", {result_hi, result}, 64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("abort no out_valid", seen, 1'b0);
    chk("abort in_ready after release", in_ready, 1'b1);
    do_op(ADD, 32'd2, 32'd3, r, h, f, lat, rdy);
    chk("post-abort add result", r, 32'd5);
    chk("post-abort add flags", f, 5'b00000);
    chk("post-abort add latency", lat, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath ALU. Registers its operands and flags.
- Single-cycle logic/add/sub ops; iterative multi-cycle multiply (and, optionally, divide).
- Sits between the register-file read stage and writeback in the microprocessor; the DMA/control FSM holds off issue via ready.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  block can accept a new operation
- opcode  in  4  operation select: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 NAND, 6 NOR, 7 XOR, 8 DIV (feature-gated), 9-15 illegal
- operand1  in  WIDTH  A
- operand2  in  WIDTH  B
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  low result / quotient
- result_hi  out  WIDTH  MUL high half / DIV remainder; 0 for other ops
- flagC  out  1  carry (ADD) / borrow (SUB)
- flagZ  out  1  result==0 (low WIDTH bits only)
- flagN  out  1  result[WIDTH-1]
- flagV  out  1  signed overflow (ADD/SUB), else 0
- flag_err  out  1  illegal opcode or divide-by-zero

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=0 while rst is high and 1 from the first clock after release; out_valid=0; result, result_hi and all flags = 0; counter cleared.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch opcode and operands.
  - Single-cycle ops (0,1,3-7, illegal): compute and go to DONE. out_valid is asserted the cycle after acceptance (latency 1).
  - MUL/DIV: go to BUSY and load counter = WIDTH.
- BUSY: in_ready=0. One shift-add (MUL, unsigned) or restoring-subtract (DIV, unsigned) step per cycle. Counter decrements; at counter==1 the final step is written and the state moves to DONE. Total latency from acceptance to out_valid is WIDTH+1 cycles (33 at default).
- DONE: out_valid=1; outputs stable until out_valid&&out_ready, then return to IDLE. in_ready=0 in DONE (no overlap; throughput 1 op per 2 cycles minimum).
- ADD: {flagC,result} = A+B computed at WIDTH+1 bits; flagC = bit WIDTH.
- SUB: result = A-B; flagC=1 when A<B (unsigned borrow).
- flagV (ADD): A and B have the same sign and the result sign differs. flagV (SUB): A and B have different signs and the result sign differs from A.
- MUL: full 2*WIDTH product split into result_hi:result. flagC = (result_hi!=0). flagV=0.
- Logic ops: flagC=0, flagV=0.
- DIV by zero: result = all ones, result_hi = A, flag_err=1, latency unchanged.
- Illegal opcode: result=0, result_hi=0, all flags 0 except flag_err=1; latency 1.
- Flags are updated only when out_valid rises and hold their value until the next result.
- rst asserted mid-BUSY/DONE: the operation is aborted immediately, no out_valid is produced, and all outputs return to their reset values.
- in_valid while not ready is ignored; the operands are not latched.

Optional Feature:
- Macro ALU_SEQ_DIV_EN.
- Defined: opcode 8 performs iterative unsigned divide as specified above.
- Undefined: no divider logic is built; opcode 8 is treated as illegal (latency 1, flag_err=1, result 0).

Decomposition:
- Package alu_seq_pkg holds:
  - the opcode enum (4-bit typedef) with the named constants ADD..DIV;
  - the state enum (IDLE/BUSY/DONE);
  - the flags struct {C,Z,N,V,err}.
- One natural sub-module: alu_seq_iter, the shift-add/restoring-divide datapath with start/done. The top handles handshake, single-cycle ops and flag generation.

Test Plan (WIDTH=32):
- ADD A=0xFFFFFFFF, B=0x1 -> one cycle later out_valid=1, result=0, flagC=1, flagZ=1, flagV=0, flagN=0.
- SUB A=0x80000000, B=0x1 -> result=0x7FFFFFFF, flagV=1, flagC=0, flagN=0. SUB A=3, B=5 -> result=0xFFFFFFFE, flagC=1, flagN=1.
- MUL A=0x10000, B=0x10000 -> out_valid exactly 33 cycles after acceptance, result=0, result_hi=0x1, flagZ=1, flagC=1. in_ready stays low throughout.
- Backpressure: XOR A=0xF0F0F0F0, B=0xFFFFFFFF with out_ready=0 for 5 cycles -> result=0x0F0F0F0F held stable and in_ready=0. A new in_valid during this window is ignored. The op completes on the first out_ready cycle.
- With ALU_SEQ_DIV_EN: DIV A=100, B=7 -> result=14, result_hi=2. DIV A=5, B=0 -> result=0xFFFFFFFF, result_hi=5, flag_err=1. Without the macro, opcode 8 -> flag_err=1 after 1 cycle. Opcode 12 -> flag_err=1 in both builds.
- Assert rst at cycle 10 of a MUL -> out_valid never pulses. After release, in_ready=1 and a following ADD 2+3 returns result=5.
